// File: rtl/muskbus_writeback_queue_if.sv
// Bundle between the write-back queue, the evicting cache (enq/probe side) and the Muskbus line writer.
// The slave modport is the queue itself. The master modport is the surrounding cache/writer logic.
interface muskbus_writeback_queue_if #(
  parameter int DEPTH     = 4,
  parameter int LINE_BITS = 512
);
  logic                   enq_valid;
  logic                   enq_ready;
  logic [63:0]            enq_addr;
  logic [0:LINE_BITS-1]   enq_data;

  logic                   wr_reqcyc;
  logic [63:0]            wr_addr;
  logic [0:LINE_BITS-1]   wr_data;
  logic                   wr_respcyc;

  logic [63:0]            probe_addr;
  logic                   probe_hit;
  logic [0:LINE_BITS-1]   probe_data;

  logic [$clog2(DEPTH):0] count;

  modport master (
    output enq_valid, enq_addr, enq_data, wr_respcyc, probe_addr,
    input  enq_ready, wr_reqcyc, wr_addr, wr_data, probe_hit, probe_data, count
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, wr_respcyc, probe_addr,
    output enq_ready, wr_reqcyc, wr_addr, wr_data, probe_hit, probe_data, count
  );
endinterface

// File: rtl/muskbus_writeback_queue.sv
// Write-back queue: holds evicted dirty lines and feeds them one at a time to the Muskbus line writer.
// Defining MUSKBUS_WBQ_COALESCE_EN merges a re-eviction into a pending entry that is not in flight.
module muskbus_writeback_queue #(
  parameter int DEPTH     = 4,
  parameter int LINE_BITS = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  muskbus_writeback_queue_if.slave bus
);
  localparam int          PTR_W     = $clog2(DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [63:0] LINE_MASK = ~64'h3f;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_next;
  logic [DEPTH-1:0]     valid;
  logic                 wr_reqcyc_q;
  logic [63:0]          addr_mem [DEPTH];
  logic [0:LINE_BITS-1] data_mem [DEPTH];

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 coalesce;
  logic                 coal_hit;
  logic [PTR_W-1:0]     coal_idx;
  logic                 probe_hit_c;
  logic [0:LINE_BITS-1] probe_data_c;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    logic [PTR_W-1:0] slot;
    probe_hit_c  = 1'b0;
    probe_data_c = '0;
    slot         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (valid[slot] && (addr_mem[slot] == (bus.probe_addr & LINE_MASK))) begin
        probe_hit_c  = 1'b1;
        probe_data_c = data_mem[slot];
      end
    end
  end

`ifdef MUSKBUS_WBQ_COALESCE_EN
  always_comb begin
    logic [PTR_W-1:0] slot;
    coal_hit = 1'b0;
    coal_idx = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (valid[slot] && !((state == WAIT) && (slot == head)) &&
          (addr_mem[slot] == (bus.enq_addr & LINE_MASK))) begin
        coal_hit = 1'b1;
        coal_idx = slot;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign coalesce   = bus.enq_valid && coal_hit;
  assign push       = bus.enq_valid && !full && !coal_hit;
  assign pop        = (state == WAIT) && bus.wr_respcyc;
  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  assign bus.enq_ready  = !full || coal_hit;
  assign bus.wr_reqcyc  = wr_reqcyc_q;
  assign bus.wr_addr    = addr_mem[head];
  assign bus.wr_data    = data_mem[head];
  assign bus.probe_hit  = probe_hit_c;
  assign bus.probe_data = probe_data_c;
  assign bus.count      = count_q;

  // wr_reqcyc is registered from next-state values, so it is high exactly in the IDLE cycle with work pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      valid       <= '0;
      wr_reqcyc_q <= 1'b0;
    end else begin
      count_q <= count_next;
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case (state)
        IDLE: begin
          wr_reqcyc_q <= empty && push;
          if (!empty) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wr_reqcyc_q <= bus.wr_respcyc && (count_next != '0);
          if (bus.wr_respcyc) begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          wr_reqcyc_q <= 1'b0;
        end
      endcase
    end
  end

  // Line storage is deliberately left out of reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (coalesce) begin
      data_mem[coal_idx] <= bus.enq_data;
    end else if (push) begin
      addr_mem[tail] <= bus.enq_addr & LINE_MASK;
      data_mem[tail] <= bus.enq_data;
    end
  end
endmodule
